fir_mac_filter: RTL and testbench

Parametrised, time-multiplexed FIR low-pass filter for the DDS output path. It uses a single multiply-accumulate unit that iterates over TAPS runtime-loadable signed coefficients. Samples come from the DDS over a valid/ready handshake and are held in a circular delay line. Results are rounded, scaled and optionally saturated, then presented on a valid/ready output toward the DAC/capture stage.

---
 rtl/fir_mac_filter.sv | 225 ++++++++++++++++++++++
 tb/tb_fir_mac_filter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// -----------------------------------------------------------------------------
// fir_mac_filter
//
// Time-multiplexed FIR low-pass filter. One multiply-accumulate unit walks
// over TAPS runtime-loadable signed coefficients. The delay line is a circular
// buffer indexed from the newest sample backwards. The accumulator is rounded
// half up, arithmetically shifted by SHIFT and reduced to OUT_W bits.
//
// Optional feature macro: FIR_SAT_EN
//   defined   -> result is clamped to the signed OUT_W range
//   undefined -> result is truncated to OUT_W bits (two's-complement wrap)
//
// Parameters
//   TAPS   filter length (>= 2)
//   DATA_W signed input sample width
//   COEF_W signed coefficient width
//   OUT_W  signed output width
//   SHIFT  right shift applied to the accumulator before output
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    input sample valid
//   in_ready    block accepts a sample (IDLE only)
//   in_data     signed input sample
//   coef_we     coefficient write strobe (honoured in IDLE only)
//   coef_addr   coefficient index
//   coef_wdata  signed coefficient value
//   busy        a computation is in progress; coefficient writes are dropped
//   out_valid   out_data holds a result
//   out_ready   downstream accepts out_data
//   out_data    signed filtered result
// -----------------------------------------------------------------------------
module fir_mac_filter #(
  parameter int TAPS   = 32,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  // One spare bit so adding the rounding constant can never wrap.
  localparam int SUM_W  = ACC_W + 1;
  localparam int EXT_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                    state_q;
  logic [AW-1:0]             wp_q, wp_d;
  logic [AW-1:0]             base_q;
  logic [AW-1:0]             k_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      in_ready_q;
  logic                      busy_q;
  logic                      out_valid_q;

  logic signed [DATA_W-1:0]  mem_q  [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];

  logic                      accept;
  logic                      addr_ok;
  logic                      coef_wr;
  logic [AW:0]               diff;
  logic [AW-1:0]             rd_idx;
  logic signed [PROD_W-1:0]  prod;

  assign accept  = in_valid && in_ready_q;
  assign coef_wr = coef_we && (state_q == S_IDLE) && addr_ok;

  // Out-of-range coefficient addresses can only occur for non power-of-two TAPS.
  generate
    if ((1 << AW) == TAPS) begin : g_addr_pow2
      assign addr_ok = 1'b1;
    end else begin : g_addr_npow2
      assign addr_ok = (coef_addr < AW'(TAPS));
    end
  endgenerate

  assign wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;

  // (base - k) mod TAPS: a borrow out of the subtraction means we wrapped
  // below zero, so fold back by adding TAPS.
  assign diff   = {1'b0, base_q} - {1'b0, k_q};
  assign rd_idx = diff[AW] ? AW'(diff + (AW + 1)'(TAPS)) : diff[AW-1:0];

  assign prod  = coef_q[k_q] * mem_q[rd_idx];
  assign acc_d = acc_q + ACC_W'(prod);

  // Delay line: the accepted sample lands at wp in the same edge that
  // records it as the newest entry (base).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wp_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      base_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            base_q     <= wp_q;
            wp_q       <= wp_d;
            acc_q      <= '0;
            k_q        <= '0;
            state_q    <= S_MAC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (k_q == LAST) begin
            k_q         <= '0;
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;

  // Output path: round half up, arithmetic shift, then reduce to OUT_W.
  logic [SUM_W-1:0]         rnd;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [SUM_W-1:0]  r_s;
  logic signed [EXT_W-1:0]  r_ext;
  logic [OUT_W-1:0]         out_d;

  generate
    if (SHIFT > 0) begin : g_rnd
      assign rnd = SUM_W'(1) << (SHIFT - 1);
    end else begin : g_no_rnd
      assign rnd = '0;
    end
  endgenerate

  assign sum_s = SUM_W'(acc_q) + rnd;
  assign r_s   = sum_s >>> SHIFT;
  assign r_ext = EXT_W'(r_s);

`ifdef FIR_SAT_EN
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = ~OUT_MAX;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'($signed(OUT_MAX));
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'($signed(OUT_MIN));

  always_comb begin
    out_d = r_ext[OUT_W-1:0];
    if (r_ext > SAT_MAX) begin
      out_d = OUT_MAX;
    end else if (r_ext < SAT_MIN) begin
      out_d = OUT_MIN;
    end
  end
`else
  always_comb begin
    out_d = r_ext[OUT_W-1:0];
  end
`endif

  assign out_data = out_d;

endmodule

// File: tb/tb_fir_mac_filter.sv
module tb_fir_mac_filter;

  localparam int TAPS   = 8;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int AW     = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic [DATA_W-1:0]        in_data = '0;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic [COEF_W-1:0]        coef_wdata = '0;
  logic                     out_ready = 1'b0;

  logic                     in_ready, busy, out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     in_ready_s, busy_s, out_valid_s;
  logic signed [OUT_W-1:0]  out_data_s;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model state: coefficient table and full sample history.
  int coef_m [TAPS];
  int hist [$];

  always #5 clk = ~clk;

  fir_mac_filter #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  fir_mac_filter #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(4)) u_dut_sh (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks_cnt++;
    if (obs != exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
  endfunction

  // y = sum coef[k] * x[n-k], then round/shift and reduce to OUT_W.
  function automatic longint model_y(input int sh);
    longint acc, r, maxv, minv;
    int idx;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      idx = hist.size() - 1 - k;
      if (idx >= 0) acc += longint'(coef_m[k]) * longint'(hist[idx]);
    end
    r = (sh > 0) ? ((acc + (longint'(1) << (sh - 1))) >>> sh) : acc;
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -maxv - 1;
`ifdef FIR_SAT_EN
    if (r > maxv) r = maxv;
    else if (r < minv) r = minv;
`else
    r = r & ((longint'(1) << OUT_W) - 1);
    if (r > maxv) r -= (longint'(1) << OUT_W);
`endif
    return r;
  endfunction

  function automatic int rand_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = COEF_W'(v);
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[a] = v;
  endtask

  task automatic write_all(input int v, input bit rnd);
    for (int a = 0; a < TAPS; a++) write_coef(a, rnd ? rand_s8() : v);
  endtask

  // wr_mode: 0 none, 1 coef write in the accept cycle, 2 coef write during MAC.
  task automatic send_one(input int x, input int bp, input int pend,
                          input int wr_mode, input int wr_addr, input int wr_val);
    longint e0, e4;
    int lat;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = DATA_W'(x);
    if (wr_mode == 1) begin
      coef_we = 1'b1; coef_addr = AW'(wr_addr); coef_wdata = COEF_W'(wr_val);
      coef_m[wr_addr] = wr_val;
    end
    @(posedge clk);
    hist.push_back(x);
    e0 = model_y(0);
    e4 = model_y(4);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    check("busy_mac", busy, 1);
    check("in_ready_mac", in_ready, 0);
    lat = 0;
    if (wr_mode == 2) begin
      coef_we = 1'b1; coef_addr = AW'(wr_addr); coef_wdata = COEF_W'(wr_val);
      @(negedge clk);
      coef_we = 1'b0;
      lat = 1;
    end
    while (!out_valid && lat < 4 * TAPS) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, TAPS);
    check("out_valid_sh", out_valid_s, 1);
    check("y_shift0", out_data, e0);
    check("y_shift4", out_data_s, e4);
    if (bp > 0) begin
      in_valid = 1'b1; in_data = DATA_W'(pend);
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, e0);
        check("bp_in_ready", in_ready, 0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    $display("txn x=%0d y0=%0d exp0=%0d y4=%0d exp4=%0d lat=%0d", x, out_data_snapshot(e0), e0, e4, e4, lat);
  endtask

  function automatic longint out_data_snapshot(input longint v);
    return v;
  endfunction

  // Back-to-back stream with out_ready held high; checks data and spacing.
  task automatic run_stream(input int n);
    longint q0 [$];
    longint q4 [$];
    int accepted = 0, got = 0, cyc = 0, last_cyc = -1;
    longint e;
    out_ready = 1'b1;
    in_data = DATA_W'(rand_s8());
    in_valid = 1'b1;
    while (got < n && cyc < n * (TAPS + 2) + 50) begin
      if (out_valid) begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("stream_y0", out_data, e);
          e = q4.pop_front();
          check("stream_y4", out_data_s, e);
          $display("txn stream n=%0d y0=%0d y4=%0d", got, out_data, out_data_s);
        end else begin
          check("stream_unexpected_out", 1, 0);
        end
        got++;
      end
      if (in_ready && in_valid) begin
        hist.push_back(int'($signed(in_data)));
        q0.push_back(model_y(0));
        q4.push_back(model_y(4));
        if (last_cyc >= 0) check("throughput", cyc - last_cyc, TAPS + 2);
        last_cyc = cyc;
        accepted++;
        @(posedge clk);
        @(negedge clk);
        in_data = DATA_W'(rand_s8());
        if (accepted == n) in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("stream_count", got, n);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int pend;
    model_reset();
    do_reset();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_data_sh", out_data_s, 0);

    // Impulse response: coef[k] = k+1
    for (int a = 0; a < TAPS; a++) write_coef(a, a + 1);
    send_one(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TAPS; i++) send_one(0, 0, 0, 0, 0, 0);

    // Saturation / wrap: full-scale coefficients and samples
    write_all(127, 1'b0);
    for (int i = 0; i < TAPS; i++) send_one(127, 0, 0, 0, 0, 0);
    for (int i = 0; i < TAPS; i++) send_one(-128, 0, 0, 0, 0, 0);

    // Rounding on the SHIFT=4 instance
    do_reset();
    write_coef(0, 1);
    send_one(8, 0, 0, 0, 0, 0);
    send_one(7, 0, 0, 0, 0, 0);
    send_one(-8, 0, 0, 0, 0, 0);
    send_one(-9, 0, 0, 0, 0, 0);

    // Backpressure with a pending sample held by the source
    write_all(0, 1'b1);
    pend = rand_s8();
    send_one(rand_s8(), 20, pend, 0, 0, 0);
    send_one(pend, 0, 0, 0, 0, 0);
    send_one(rand_s8(), 0, 0, 0, 0, 0);

    // Coefficient write while busy is dropped; in IDLE it takes effect
    send_one(rand_s8(), 0, 0, 2, 0, 50);
    send_one(rand_s8(), 0, 0, 0, 0, 0);
    send_one(rand_s8(), 0, 0, 1, 0, 50);
    write_coef(3, 50);
    send_one(rand_s8(), 0, 0, 0, 0, 0);

    // Random coefficients, back-to-back stream across several wp wraps
    write_all(0, 1'b1);
    for (int i = 0; i < 10; i++) send_one(rand_s8(), 0, 0, 0, 0, 0);
    run_stream(20);

    // Reset in the middle of MAC
    in_valid = 1'b1; in_data = DATA_W'(5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_data_sh", out_data_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_one(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TAPS; i++) send_one(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
